seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
Receive side of the team's multiplexed 2-digit 7-segment display interface (seg_sel one-hot digit strobe plus seg_out {DP,g..a} pattern).
- Samples the scan bus and decodes each digit pattern back to BCD.
- Reassembles the tens/ones pair and publishes a registered BCD and binary value with an update strobe.
- Used as an on-chip self-check monitor behind the 00-99 counter/display driver, and as a bench reference model.

Parameters:
STABLE_CYCLES, 4, consecutive identical registered samples required before a digit is accepted (>=2).
TIMEOUT_CYCLES, 262144, cycles without any accepted digit before scan_timeout asserts.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
seg_sel  input  4  digit strobe: 4'b0001 = ones, 4'b0010 = tens.
seg_out  input  8  {DP, g,f,e,d,c,b,a}, bit0 = segment a, active-high.
err_clr  input  1  clears seg_err and sel_err.
ones  output  4  last published ones digit (BCD).
tens  output  4  last published tens digit (BCD).
value_bin  output  7  tens*10+ones, 0..99.
value_update  output  1  one-cycle pulse when a new pair is published.
value_valid  output  1  high after the first publish; low after reset or timeout.
seg_err  output  1  sticky: illegal segment pattern seen.
sel_err  output  1  sticky: illegal seg_sel code seen.
scan_timeout  output  1  high while no digit has been accepted for TIMEOUT_CYCLES.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, FSM in IDLE, all counters 0, sample register 0.
- Input stage: {seg_sel,seg_out} registered once into s_q.
- Stability counter: counts 1..STABLE_CYCLES while s_q is unchanged, and restarts at 1 when s_q changes.
- Capture event: fires in the cycle where the stability count reaches STABLE_CYCLES, exactly once per stable window.
- Latency: a bus value first driven in cycle N is in s_q at N+1 and captured at N+STABLE_CYCLES. Published outputs are visible at N+STABLE_CYCLES+1.
- DP is ignored.
- Pattern decode (bits g..a):
  - 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9.
  - Any other pattern is illegal.
- seg_sel handling at capture:
  - 0000: blank; no effect, no error, timeout counter not reset.
  - 0001 / 0010: digit capture.
  - Any other code: sel_err<=1; FSM returns to IDLE.
- Illegal pattern on a digit capture: seg_err<=1; FSM returns to IDLE; the partial frame is dropped.
- FSM states: IDLE, HAVE_ONES. On a legal capture:
  - IDLE + ones: latch ones_tmp -> HAVE_ONES.
  - IDLE + tens: stay IDLE (no preceding ones).
  - HAVE_ONES + ones: overwrite ones_tmp, stay.
  - HAVE_ONES + tens: publish -> IDLE.
- Publish: tens/ones <= captured pair; value_bin <= tens*10+ones (registered, 7-bit); value_update=1 for one cycle; value_valid<=1.
  - Publishing an unchanged value still pulses value_update.
- Timeout:
  - Counter is cleared on every legal digit capture and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: scan_timeout<=1, value_valid<=0, FSM->IDLE. ones/tens/value_bin hold their last values.
  - scan_timeout clears on the next legal digit capture.
- err_clr: clears both sticky flags. If a new error is detected in the same cycle, the error wins and the flag stays 1.
- Reset asserted mid-frame: discards ones_tmp and all state; no value_update pulse in the reset cycle or the cycle after.

Test Plan:
1. Drive seg_sel=0001, seg_out=0x4F (3) for 8 cycles, then seg_sel=0010, seg_out=0x6D (5) for 8 cycles -> one value_update pulse; tens=5, ones=3, value_bin=53, value_valid=1, no errors.
2. Toggle the bus every 3 cycles with STABLE_CYCLES=4 -> no capture, no value_update; a 4-cycle hold yields a capture at exactly N+4, with outputs visible at N+5.
3. Ones=0x3F (0), held stable; then tens=0x3E (illegal) -> seg_err=1, no publish. err_clr pulse -> seg_err=0. Next valid pair 0x07/0x6F publishes 97.
4. Hold seg_sel=0100 stable -> sel_err=1 and FSM IDLE. Assert err_clr in the same cycle as a second illegal-sel capture -> sel_err stays 1.
5. After publishing 42, stop the scan (seg_sel=0000) for TIMEOUT_CYCLES (bench override 64) -> scan_timeout=1, value_valid=0, ones=2/tens=4 held. The next legal capture clears scan_timeout.
6. Capture ones=8, then assert rst one cycle before the tens capture completes -> all outputs 0 and no value_update. A subsequent tens-only capture does not publish.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Receive side of the multiplexed 2-digit 7-segment scan bus. Samples
// {seg_sel, seg_out}, waits for a stable window, decodes the segment pattern
// back to BCD, pairs ones/tens and publishes a registered BCD/binary value.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] seg_sel,
  input  logic [7:0] seg_out,
  input  logic       err_clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] value_bin,
  output logic       value_update,
  output logic       value_valid,
  output logic       seg_err,
  output logic       sel_err,
  output logic       scan_timeout
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_ONE = SW'(1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_PRE   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    HAVE_ONES = 1'b1
  } state_t;

  // Returns {legal, digit}; bits g..a only, DP is not part of the code.
  function automatic logic [4:0] f_decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b0111111: res = {1'b1, 4'd0};
      7'b0000110: res = {1'b1, 4'd1};
      7'b1011011: res = {1'b1, 4'd2};
      7'b1001111: res = {1'b1, 4'd3};
      7'b1100110: res = {1'b1, 4'd4};
      7'b1101101: res = {1'b1, 4'd5};
      7'b1111101: res = {1'b1, 4'd6};
      7'b0000111: res = {1'b1, 4'd7};
      7'b1111111: res = {1'b1, 4'd8};
      7'b1101111: res = {1'b1, 4'd9};
      default:    res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  logic [11:0]   r_s_q;
  logic [SW-1:0] r_stab_cnt;
  logic          r_cap;
  logic [TW-1:0] r_to_cnt;
  state_t        r_state;
  logic [3:0]    r_ones_tmp;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic [6:0]    r_value_bin;
  logic          r_value_update;
  logic          r_value_valid;
  logic          r_seg_err;
  logic          r_sel_err;
  logic          r_scan_timeout;

  logic [11:0] w_bus;
  logic [3:0]  w_sel;
  logic [4:0]  w_dec;
  logic [3:0]  w_dig;
  logic        w_is_ones;
  logic        w_is_tens;
  logic        w_is_blank;
  logic        w_dig_cap;
  logic        w_legal;
  logic        w_seg_bad;
  logic        w_sel_bad;
  logic        w_to_hit;
  logic [6:0]  w_tens7;
  logic [6:0]  w_pub_bin;

  assign w_bus      = {seg_sel, seg_out};
  assign w_sel      = r_s_q[11:8];
  assign w_dec      = f_decode(r_s_q[6:0]);
  assign w_dig      = w_dec[3:0];
  assign w_is_ones  = (w_sel == 4'b0001);
  assign w_is_tens  = (w_sel == 4'b0010);
  assign w_is_blank = (w_sel == 4'b0000);
  assign w_dig_cap  = r_cap && (w_is_ones || w_is_tens);
  assign w_legal    = w_dig_cap && w_dec[4];
  assign w_seg_bad  = w_dig_cap && !w_dec[4];
  assign w_sel_bad  = r_cap && !(w_is_ones || w_is_tens || w_is_blank);
  // The saturated count never equals TO_PRE, so this fires once per silence.
  assign w_to_hit   = !w_legal && (r_to_cnt == TO_PRE);
  // tens*10 + ones as (tens<<3) + (tens<<1) + ones; max 99 fits in 7 bits.
  assign w_tens7    = {3'b000, w_dig};
  assign w_pub_bin  = (w_tens7 << 3'd3) + (w_tens7 << 3'd1) + {3'b000, r_ones_tmp};

  // Input register plus stability counter; r_cap marks the single capture cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q      <= 12'h000;
      r_stab_cnt <= {SW{1'b0}};
      r_cap      <= 1'b0;
    end else begin
      r_s_q <= w_bus;
      if (w_bus != r_s_q) begin
        r_stab_cnt <= STAB_ONE;
        r_cap      <= 1'b0;
      end else if (r_stab_cnt != STAB_MAX) begin
        r_stab_cnt <= r_stab_cnt + STAB_ONE;
        r_cap      <= (r_stab_cnt == STAB_PRE);
      end else begin
        r_stab_cnt <= r_stab_cnt;
        r_cap      <= 1'b0;
      end
    end
  end

  // Frame FSM, publish registers, sticky error flags and scan timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_ones_tmp     <= 4'd0;
      r_ones         <= 4'd0;
      r_tens         <= 4'd0;
      r_value_bin    <= 7'd0;
      r_value_update <= 1'b0;
      r_value_valid  <= 1'b0;
      r_seg_err      <= 1'b0;
      r_sel_err      <= 1'b0;
      r_scan_timeout <= 1'b0;
      r_to_cnt       <= {TW{1'b0}};
    end else begin
      r_value_update <= 1'b0;

      // A fresh error outranks a simultaneous clear request.
      if (w_seg_bad) begin
        r_seg_err <= 1'b1;
      end else if (err_clr) begin
        r_seg_err <= 1'b0;
      end else begin
        r_seg_err <= r_seg_err;
      end

      if (w_sel_bad) begin
        r_sel_err <= 1'b1;
      end else if (err_clr) begin
        r_sel_err <= 1'b0;
      end else begin
        r_sel_err <= r_sel_err;
      end

      if (w_legal) begin
        r_to_cnt       <= {TW{1'b0}};
        r_scan_timeout <= 1'b0;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end else begin
        r_to_cnt <= r_to_cnt;
      end

      if (w_to_hit) begin
        r_scan_timeout <= 1'b1;
        r_value_valid  <= 1'b0;
      end

      if (w_seg_bad || w_sel_bad || w_to_hit) begin
        r_state <= IDLE;
      end else if (w_legal) begin
        case (r_state)
          IDLE: begin
            if (w_is_ones) begin
              r_ones_tmp <= w_dig;
              r_state    <= HAVE_ONES;
            end else begin
              r_state <= IDLE;
            end
          end
          HAVE_ONES: begin
            if (w_is_ones) begin
              r_ones_tmp <= w_dig;
              r_state    <= HAVE_ONES;
            end else begin
              r_ones         <= r_ones_tmp;
              r_tens         <= w_dig;
              r_value_bin    <= w_pub_bin;
              r_value_update <= 1'b1;
              r_value_valid  <= 1'b1;
              r_state        <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign ones         = r_ones;
  assign tens         = r_tens;
  assign value_bin    = r_value_bin;
  assign value_update = r_value_update;
  assign value_valid  = r_value_valid;
  assign seg_err      = r_seg_err;
  assign sel_err      = r_sel_err;
  assign scan_timeout = r_scan_timeout;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: table of scan-bus holds with expected
// published outputs, plus directed sequences for latency, errors, timeout
// and reset in the middle of a frame.
module tb_seg7_scan_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] seg_sel;
  logic [7:0] seg_out;
  logic       err_clr;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [6:0] value_bin;
  logic       value_update;
  logic       value_valid;
  logic       seg_err;
  logic       sel_err;
  logic       scan_timeout;

  int checks;
  int errors;
  int upd_cnt;

  seg7_scan_decoder #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_sel     (seg_sel),
    .seg_out     (seg_out),
    .err_clr     (err_clr),
    .ones        (ones),
    .tens        (tens),
    .value_bin   (value_bin),
    .value_update(value_update),
    .value_valid (value_valid),
    .seg_err     (seg_err),
    .sel_err     (sel_err),
    .scan_timeout(scan_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
    logic [3:0] e_ones;
    logic [3:0] e_tens;
    logic [6:0] e_bin;
    logic       e_valid;
    int         e_upd;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [31:0] outs();
    return {13'd0, ones, tens, value_bin, value_valid, seg_err, sel_err, scan_timeout};
  endfunction

  function automatic logic [31:0] ev(input logic [3:0] o, input logic [3:0] t,
                                     input logic [6:0] b, input logic v,
                                     input logic se, input logic sl, input logic to);
    return {13'd0, o, t, b, v, se, sl, to};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // one clock: inputs change at negedge, outputs sampled at the next negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (value_update === 1'b1) upd_cnt++;
  endtask

  task automatic hold(input logic [3:0] s, input logic [7:0] p, input int n);
    seg_sel = s;
    seg_out = p;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    err_clr = 1'b0;
    seg_sel = 4'd0;
    seg_out = 8'h00;
    step();
    step();
    rst = 1'b0;
    upd_cnt = 0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    upd_cnt = 0;
    rst     = 1'b1;
    err_clr = 1'b0;
    seg_sel = 4'd0;
    seg_out = 8'h00;

    //            sel   seg    ones  tens  bin    valid upd
    tbl[0]  = '{4'd1, 8'h4F, 4'd0, 4'd0, 7'd0,  1'b0, 0};
    tbl[1]  = '{4'd2, 8'h6D, 4'd3, 4'd5, 7'd53, 1'b1, 1};
    tbl[2]  = '{4'd1, 8'h86, 4'd3, 4'd5, 7'd53, 1'b1, 0};
    tbl[3]  = '{4'd2, 8'h7F, 4'd1, 4'd8, 7'd81, 1'b1, 1};
    tbl[4]  = '{4'd1, 8'h6F, 4'd1, 4'd8, 7'd81, 1'b1, 0};
    tbl[5]  = '{4'd2, 8'h3F, 4'd9, 4'd0, 7'd9,  1'b1, 1};
    tbl[6]  = '{4'd1, 8'h07, 4'd9, 4'd0, 7'd9,  1'b1, 0};
    tbl[7]  = '{4'd1, 8'h5B, 4'd9, 4'd0, 7'd9,  1'b1, 0};
    tbl[8]  = '{4'd2, 8'h7D, 4'd2, 4'd6, 7'd62, 1'b1, 1};
    tbl[9]  = '{4'd2, 8'h66, 4'd2, 4'd6, 7'd62, 1'b1, 0};
    tbl[10] = '{4'd1, 8'h5B, 4'd2, 4'd6, 7'd62, 1'b1, 0};
    tbl[11] = '{4'd2, 8'h7D, 4'd2, 4'd6, 7'd62, 1'b1, 1};
    tbl[12] = '{4'd1, 8'h3F, 4'd2, 4'd6, 7'd62, 1'b1, 0};
    tbl[13] = '{4'd2, 8'h6F, 4'd0, 4'd9, 7'd90, 1'b1, 1};
    tbl[14] = '{4'd0, 8'h00, 4'd0, 4'd9, 7'd90, 1'b1, 0};
    tbl[15] = '{4'd1, 8'h6D, 4'd0, 4'd9, 7'd90, 1'b1, 0};
    tbl[16] = '{4'd2, 8'h66, 4'd5, 4'd4, 7'd45, 1'b1, 1};

    @(negedge clk);
    do_reset();
    chk("reset_outputs", outs(), ev(4'd0, 4'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("reset_update", {31'd0, value_update}, 32'd0);

    // table: each row held 8 cycles, then outputs and pulse count compared
    for (int i = 0; i < 17; i++) begin
      upd_cnt = 0;
      hold(tbl[i].sel, tbl[i].seg, 8);
      chk($sformatf("row%0d_outs", i), outs(),
          ev(tbl[i].e_ones, tbl[i].e_tens, tbl[i].e_bin, tbl[i].e_valid, 1'b0, 1'b0, 1'b0));
      chk($sformatf("row%0d_upd", i), upd_cnt, tbl[i].e_upd);
    end

    // 3-cycle toggling never captures; then exact capture latency
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) hold(4'd1, 8'h06, 3);
      else            hold(4'd2, 8'h5B, 3);
    end
    chk("toggle_no_update", upd_cnt, 0);
    chk("toggle_no_valid", {31'd0, value_valid}, 32'd0);
    hold(4'd1, 8'h4F, 8);
    seg_sel = 4'd2;
    seg_out = 8'h6D;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("lat_pre%0d", k), {31'd0, value_update}, 32'd0);
    end
    step();
    chk("lat_publish", {24'd0, value_update, value_bin}, {24'd0, 1'b1, 7'd53});

    // illegal pattern, clear, dropped frame, then a good pair
    do_reset();
    hold(4'd1, 8'h3F, 8);
    hold(4'd2, 8'h3E, 8);
    chk("segerr_set", outs(), ev(4'd0, 4'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    chk("segerr_no_upd", upd_cnt, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("segerr_clr", {31'd0, seg_err}, 32'd0);
    hold(4'd2, 8'h4F, 8);
    chk("segerr_dropped", upd_cnt, 0);
    hold(4'd1, 8'h07, 8);
    hold(4'd2, 8'h6F, 8);
    chk("pair97", outs(), ev(4'd7, 4'd9, 7'd97, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("pair97_upd", upd_cnt, 1);

    // illegal select code
    do_reset();
    hold(4'd1, 8'h06, 8);
    hold(4'b0100, 8'h3F, 8);
    chk("selerr_set", {30'd0, sel_err, seg_err}, {30'd0, 1'b1, 1'b0});
    hold(4'd2, 8'h5B, 8);
    chk("selerr_idle", {31'd0, value_valid}, 32'd0);
    chk("selerr_no_upd", upd_cnt, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("selerr_clr", {31'd0, sel_err}, 32'd0);
    seg_sel = 4'b0100;
    seg_out = 8'h06;
    repeat (4) step();
    chk("selerr_before", {31'd0, sel_err}, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("selerr_wins", {31'd0, sel_err}, 32'd1);

    // timeout after a publish of 42 (override 64 cycles)
    do_reset();
    hold(4'd1, 8'h5B, 8);
    hold(4'd2, 8'h66, 8);
    chk("pub42", outs(), ev(4'd2, 4'd4, 7'd42, 1'b1, 1'b0, 1'b0, 1'b0));
    hold(4'd0, 8'h00, 60);
    chk("to_before", outs(), ev(4'd2, 4'd4, 7'd42, 1'b1, 1'b0, 1'b0, 1'b0));
    step();
    chk("to_hit", outs(), ev(4'd2, 4'd4, 7'd42, 1'b0, 1'b0, 1'b0, 1'b1));
    hold(4'd1, 8'h6D, 8);
    chk("to_cleared", outs(), ev(4'd2, 4'd4, 7'd42, 1'b0, 1'b0, 1'b0, 1'b0));

    // reset one cycle before the tens capture completes
    do_reset();
    hold(4'd1, 8'h5B, 8);
    hold(4'd2, 8'h06, 8);
    chk("pub12", outs(), ev(4'd2, 4'd1, 7'd12, 1'b1, 1'b0, 1'b0, 1'b0));
    hold(4'd1, 8'h7F, 8);
    upd_cnt = 0;
    seg_sel = 4'd2;
    seg_out = 8'h4F;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_outs", outs(), ev(4'd0, 4'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    chk("rst_after_outs", outs(), ev(4'd0, 4'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("rst_no_upd", upd_cnt, 0);
    hold(4'd2, 8'h4F, 8);
    chk("tens_only_outs", outs(), ev(4'd0, 4'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("tens_only_upd", upd_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
